// File: rtl/pendigits_mlp_classifier.sv
// pendigits_mlp_classifier: 3-stage pipelined 16-4-10 MLP digit classifier with loadable weights
module pendigits_mlp_classifier #(
  parameter int NUM_A = 16,
  parameter int WIDTH_A = 4,
  parameter int OUTWIDTH = 4,
  parameter int SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic                       in_valid,
  input  logic                       wr_en,
  input  logic [6:0]                 wr_addr,
  input  logic signed [7:0]          wr_data,
  output logic [OUTWIDTH-1:0]        out,
  output logic                       out_valid
);
  localparam int NH = 4;
  localparam int NO = 10;
  localparam int B1_BASE = NUM_A * NH;
  localparam int W2_BASE = B1_BASE + NH;
  localparam int B2_BASE = W2_BASE + NO * NH;
  localparam int NW = B2_BASE + NO;
  logic signed [7:0] w [NW];
  logic [WIDTH_A-1:0] x [NUM_A];
  logic [7:0] h [NH];
  logic [7:0] hn [NH];
  logic signed [19:0] acc [NH];
  logic signed [19:0] sh [NH];
  logic signed [19:0] o [NO];
  logic signed [19:0] bv;
  logic [OUTWIDTH-1:0] bi;
  logic valid0, valid1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int a = 0; a < NW; a++) w[a] <= '0;
    end else if (wr_en && wr_addr < 7'(NW)) begin
      w[wr_addr] <= wr_data;
    end
  // Hidden layer: pre-activation is shifted arithmetically, then clamped to 0..255
  always_comb begin
    for (int j = 0; j < NH; j++) begin
      acc[j] = 20'(w[B1_BASE+j]);
      for (int i = 0; i < NUM_A; i++)
        acc[j] += $signed({1'b0, x[i]}) * w[j*NUM_A+i];
      sh[j] = acc[j] >>> SHIFT;
      hn[j] = sh[j][19] ? 8'd0 : |sh[j][18:8] ? 8'd255 : sh[j][7:0];
    end
  end
  // Output layer and argmax; strict compare keeps the lowest index on ties
  always_comb begin
    for (int k = 0; k < NO; k++) begin
      o[k] = 20'(w[B2_BASE+k]);
      for (int j = 0; j < NH; j++)
        o[k] += $signed({1'b0, h[j]}) * w[W2_BASE+k*NH+j];
    end
    bv = o[0];
    bi = '0;
    for (int k = 1; k < NO; k++) begin
      bi = o[k] > bv ? OUTWIDTH'(k) : bi;
      bv = o[k] > bv ? o[k] : bv;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_A; i++) x[i] <= '0;
      for (int j = 0; j < NH; j++) h[j] <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid)
        for (int i = 0; i < NUM_A; i++) x[i] <= inp[i*WIDTH_A +: WIDTH_A];
      valid0 <= in_valid;
      if (valid0)
        for (int j = 0; j < NH; j++) h[j] <= hn[j];
      valid1 <= valid0;
      if (valid1) out <= bi;
      out_valid <= valid1;
    end
endmodule

// File: tb/tb_pendigits_mlp_classifier.sv
// tb_pendigits_mlp_classifier: directed checks of the MLP classifier with SHIFT=4
module tb_pendigits_mlp_classifier;
  logic clk = 0;
  logic rst = 1;
  logic [63:0] inp = '0;
  logic in_valid = 0;
  logic wr_en = 0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] out;
  logic out_valid;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [63:0] ALL15 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] X0_15 = 64'h0000_0000_0000_000F;

  pendigits_mlp_classifier dut (
    .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1; wr_addr = 7'(a); wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic run(input logic [63:0] d, output logic mid, output logic v, output logic [3:0] o);
    @(negedge clk);
    in_valid = 1; inp = d;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    mid = out_valid;
    @(negedge clk);
    v = out_valid; o = out;
  endtask

  task automatic test_reset();
    logic mid, v;
    logic [3:0] o;
    do_reset();
    vectors++;
    if (out !== 4'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: out=%0d out_valid=%0b, expected 0/0", out, out_valid);
    end
    run(ALL15, mid, v, o);
    vectors++;
    if (mid !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_latency_early: out_valid=%0b one cycle early, expected 0", mid);
    end
    vectors++;
    if (v !== 1'b1 || o !== 4'd0) begin
      miscompares++;
      $display("FAIL zero_weights: out_valid=%0b out=%0d, expected 1/0", v, o);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pulse_width: out_valid=%0b, expected 0", out_valid);
    end
  endtask

  task automatic test_bias();
    logic mid, v;
    logic [3:0] o;
    do_reset();
    wr(115, 8'd5);
    run(ALL15, mid, v, o);
    vectors++;
    if (v !== 1'b1 || o !== 4'd7) begin
      miscompares++;
      $display("FAIL bias_b2_7: out_valid=%0b out=%0d, expected 1/7", v, o);
    end
    wr(111, 8'd5);
    run(ALL15, mid, v, o);
    vectors++;
    if (v !== 1'b1 || o !== 4'd3) begin
      miscompares++;
      $display("FAIL bias_tie: out_valid=%0b out=%0d, expected 1/3", v, o);
    end
  endtask

  task automatic test_single();
    logic mid, v;
    logic [3:0] o;
    do_reset();
    wr(0, 8'd1);
    wr(88, 8'd1);
    run(X0_15, mid, v, o);
    vectors++;
    if (o !== 4'd0) begin
      miscompares++;
      $display("FAIL shift_truncate: out=%0d, expected 0", o);
    end
    wr(0, 8'd16);
    run(X0_15, mid, v, o);
    vectors++;
    if (v !== 1'b1 || o !== 4'd5) begin
      miscompares++;
      $display("FAIL single_path: out_valid=%0b out=%0d, expected 1/5", v, o);
    end
    run(64'd0, mid, v, o);
    vectors++;
    if (o !== 4'd0) begin
      miscompares++;
      $display("FAIL single_path_zero: out=%0d, expected 0", o);
    end
  endtask

  task automatic test_relu();
    logic mid, v;
    logic [3:0] o;
    do_reset();
    wr(0, 8'hFF);
    wr(88, 8'd1);
    wr(110, 8'd1);
    run(X0_15, mid, v, o);
    vectors++;
    if (o !== 4'd2) begin
      miscompares++;
      $display("FAIL relu: out=%0d, expected 2", o);
    end
  endtask

  task automatic test_saturation();
    logic mid, v;
    logic [3:0] o;
    do_reset();
    for (int i = 0; i < 16; i++) wr(i, 8'd127);
    wr(84, 8'd1);
    wr(109, 8'd127);
    run(ALL15, mid, v, o);
    vectors++;
    if (o !== 4'd4) begin
      miscompares++;
      $display("FAIL saturate: out=%0d, expected 4", o);
    end
    run(X0_15, mid, v, o);
    vectors++;
    if (o !== 4'd1) begin
      miscompares++;
      $display("FAIL below_saturate: out=%0d, expected 1", o);
    end
  endtask

  task automatic test_addr();
    logic mid, v;
    logic [3:0] o;
    do_reset();
    wr(67, 8'd64);
    wr(107, 8'd1);
    wr(116, 8'd3);
    wr(120, 8'd127);
    run(64'd0, mid, v, o);
    vectors++;
    if (o !== 4'd9) begin
      miscompares++;
      $display("FAIL b1_w2_last: out=%0d, expected 9", o);
    end
    wr(116, 8'd4);
    run(64'd0, mid, v, o);
    vectors++;
    if (o !== 4'd8) begin
      miscompares++;
      $display("FAIL b2_8_tie: out=%0d, expected 8", o);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_o [3] = '{4'd5, 4'd0, 4'd5};
    do_reset();
    wr(0, 8'd16);
    wr(88, 8'd1);
    @(negedge clk) in_valid = 1; inp = X0_15;
    @(negedge clk) inp = 64'd0;
    @(negedge clk) inp = X0_15;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk) in_valid = 0;
      vectors++;
      if (out_valid !== 1'b1 || out !== exp_o[n]) begin
        miscompares++;
        $display("FAIL b2b_%0d: out_valid=%0b out=%0d, expected 1/%0d", n, out_valid, out, exp_o[n]);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || out !== 4'd5) begin
      miscompares++;
      $display("FAIL b2b_hold: out_valid=%0b out=%0d, expected 0/5", out_valid, out);
    end
  endtask

  task automatic test_midreset();
    @(negedge clk) in_valid = 1; inp = X0_15;
    @(negedge clk) inp = 64'd0;
    @(negedge clk) in_valid = 0; rst = 1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_async: out_valid=%0b out=%0d, expected 0/0", out_valid, out);
    end
    @(negedge clk) rst = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_flush_%0d: out_valid=%0b, expected 0", n, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bias();
    test_single();
    test_relu();
    test_saturation();
    test_addr();
    test_back_to_back();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pendigits_mlp_classifier.md
Name: pendigits_mlp_classifier

Overview:
- Pipelined digit classifier for the Pendigits dataset.
- Takes 16 unsigned 4-bit pen-trajectory features and emits a 4-bit class index (0..9).
- Built as a 16-4-10 MLP: one hidden layer of 4 ReLU neurons, then 10 output neurons and an argmax.
- Weights live in an on-chip register file loaded through a simple write port; the block sits behind the feature front-end as the final inference stage.

Parameters:
- NUM_A, 16, number of input features.
- WIDTH_A, 4, bits per input feature (unsigned).
- OUTWIDTH, 4, class index width.
- SHIFT, 4, arithmetic right shift applied to the hidden pre-activation before saturation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- inp  input  NUM_A*WIDTH_A (64)  features; feature i occupies bits [(i+1)*4-1 : i*4].
- in_valid  input  1  inp is sampled on this edge.
- wr_en  input  1  weight write strobe.
- wr_addr  input  7  weight address.
- wr_data  input  8  signed two's-complement weight/bias value.
- out  output  OUTWIDTH  predicted class 0..9.
- out_valid  output  1  out holds a new result this cycle.

Behaviour:
- Reset (asynchronous, active-high rst): all weight registers, pipeline registers, out and out_valid clear to 0.
- Weight address map; writes take effect at the clock edge; addresses 118..127 are ignored.
  - addr j*16+i (0..63): W1[j][i], for j=0..3, i=0..15.
  - 64+j: B1[j].
  - 68+k*4+j (68..107): W2[k][j], for k=0..9.
  - 108+k: B2[k].
- Stage 0, at an edge with in_valid=1: register the 16 features and set valid0.
- Stage 1, at the next edge: register h_j and valid1.
  - h_j = sat255(ReLU((sum_i x_i*W1[j][i] + B1[j]) >>> SHIFT)).
  - x unsigned, W signed; accumulate in at least 18-bit signed.
  - ReLU clamps negative values to 0; sat255 clamps values above 255 to 255. h_j is 8-bit unsigned.
- Stage 2, at the next edge: register out and out_valid.
  - o_k = sum_j h_j*W2[k][j] + B2[k], at least 19-bit signed.
  - out = index of the maximum o_k; ties resolve to the lowest index.
- Latency: a sample presented with in_valid at edge N gives out_valid=1 and its out after edge N+2.
- Throughput: one sample per cycle; back-to-back in_valid is fully pipelined.
- out_valid is a one-cycle pulse per sample. out holds its last value while out_valid=0.
- Each stage uses the weight register contents present at its own computing edge. A write landing mid-flight may affect a sample in flight; software loads weights before streaming inputs.
- rst asserted mid-operation discards all in-flight samples; no out_valid follows reset release until a new in_valid.
- wr_en and in_valid may be active in the same cycle.

Test Plan:
- Reset/zero weights: after rst, drive in_valid with any inp -> out_valid pulses 2 cycles later and out=0 (all o_k=0, tie to lowest index).
- Bias only: write addr 115 (B2[7]) = 5, inputs all 15 -> out=7; also write addr 111 (B2[3]) = 5 -> out=3 (tie to lowest index).
- Single path, SHIFT=0: addr 0 (W1[0][0]) = 1, addr 88 (W2[5][0]) = 1, x0=15 -> h0=15, o5=15, out=5; then x0=0 -> out=0.
- ReLU: addr 0 = -1 (0xFF), addr 88 = 1, addr 110 (B2[2]) = 1, x0=15 -> h0=0, out=2.
- Saturation, SHIFT=0: W1[0][0..15]=127, all x=15 -> h0=255; addr 84 (W2[4][0]) = 1, addr 109 (B2[1]) = 127 -> out=4.
- Pipeline/reset: three consecutive in_valid samples giving out 5, 0, 5 appear on three consecutive cycles. Asserting rst after the second sample -> out_valid=0 and out=0 immediately; no further outputs.
